// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// Holds the loader state encoding and frame geometry.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Big-endian byte-to-word packer for the boot loader.
// First byte of a word lands in [31:24].
module byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full,
  output logic        last_slot
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word      <= '0;
      cnt       <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      word      <= '0;
      cnt       <= '0;
      word_full <= 1'b0;
    end else if (shift) begin
      word      <= {word[23:0], data};
      cnt       <= cnt + 1'b1;
      word_full <= (cnt == LAST);
    end
  end

  assign last_slot = (cnt == LAST);

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the core's instruction memory.
// Keeps the core held until a checksum-verified image is written.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              restart,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t state, next;

  logic [15:0]       n_q;
  logic [15:0]       n_next;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word;
  logic [7:0]        csum;
  logic              word_full;
  logic              last_slot;
  logic              rearm;
  logic              in_write;
  logic              idx_last;
  logic              too_big;

  assign n_next   = {n_q[15:8], byte_in};
  assign in_write = (state == S_WRITE);
  assign rearm    = restart &&
                    (state == S_DONE || state == S_ERR);
  assign idx_last = (16'(index) + 16'd1) == n_q;
  assign too_big  = 17'(n_next) > 17'(DEPTH);

  byte_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (in_write || rearm),
    .shift     (state == S_DATA && byte_valid),
    .data      (byte_in),
    .word      (word),
    .word_full (word_full),
    .last_slot (last_slot)
  );

  always_comb begin
    next       = state;
    byte_ready = 1'b0;
    unique case (state)
      S_HDR_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) next = S_HDR_LO;
      end
      S_HDR_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (too_big)           next = S_ERR;
          else if (n_next == '0) next = S_CSUM;
          else                   next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && last_slot) next = S_WRITE;
      end
      S_WRITE: begin
        next = idx_last ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid)
          next = (byte_in == csum) ? S_DONE : S_ERR;
      end
      S_DONE: if (restart) next = S_HDR_HI;
      S_ERR:  if (restart) next = S_HDR_HI;
      default: next = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_HDR_HI;
    else          state <= next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_q     <= '0;
      index   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      csum    <= '0;
    end else begin
      if (state == S_HDR_HI && byte_valid)
        n_q[15:8] <= byte_in;
      if (state == S_HDR_LO && byte_valid)
        n_q[7:0] <= byte_in;
      if (state == S_DATA && byte_valid)
        csum <= csum ^ byte_in;
      // address/data outputs keep the last written word between strobes
      if (in_write) begin
        addr_q  <= index;
        wdata_q <= word;
        index   <= index + 1'b1;
      end
      if (rearm) begin
        index <= '0;
        csum  <= '0;
      end
    end
  end

  assign imem_we    = in_write && word_full;
  assign imem_addr  = in_write ? index : addr_q;
  assign imem_wdata = in_write ? word : wdata_q;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign cpu_hold   = ~done;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised frame-level bench for imem_boot_loader.
// A frame-position model predicts every write and status output.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              restart = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  always #5 clock = ~clock;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .restart    (restart),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: position in frame, word count, running xor, phase
  // (0 loading, 1 done, 2 error), and the write expected on the next cycle.
  int          m_pos;
  int          m_n;
  int          m_phase;
  logic [7:0]  m_csum;
  logic [31:0] m_acc;
  logic        m_we;
  int          m_addr;
  logic [31:0] m_data;
  logic [31:0] mem [DEPTH];
  int          wr_count;

  task automatic model_clear();
    m_pos = 0; m_n = 0; m_phase = 0;
    m_csum = '0; m_acc = '0; m_we = 1'b0;
  endtask

  initial model_clear();

  always @(negedge clock) begin
    logic nxt_we;
    if (!reset_n) begin
      model_clear();
      chk("rst_ready", 32'(byte_ready), 32'd1);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
    end else begin
      chk("we", 32'(imem_we), 32'(m_we));
      if (m_we) begin
        chk("addr", 32'(imem_addr), 32'(m_addr));
        chk("wdata", imem_wdata, m_data);
      end
      if (imem_we) begin
        mem[imem_addr] = imem_wdata;
        wr_count++;
      end
      chk("ready", 32'(byte_ready), 32'(m_phase == 0 && !m_we));
      chk("done", 32'(done), 32'(m_phase == 1));
      chk("error", 32'(error), 32'(m_phase == 2));
      chk("hold", 32'(cpu_hold), 32'(m_phase != 1));
      nxt_we = 1'b0;
      if (m_phase != 0) begin
        if (restart) model_clear();
      end else if (byte_valid && !m_we) begin
        if (m_pos == 0) begin
          m_n = int'(byte_in) * 256;
        end else if (m_pos == 1) begin
          m_n = m_n + int'(byte_in);
          if (m_n > DEPTH) m_phase = 2;
        end else if (m_pos < 2 + 4 * m_n) begin
          m_acc  = {m_acc[23:0], byte_in};
          m_csum = m_csum ^ byte_in;
          if ((m_pos - 2) % 4 == 3) begin
            nxt_we = 1'b1;
            m_addr = (m_pos - 2) / 4;
            m_data = m_acc;
          end
        end else begin
          m_phase = (byte_in == m_csum) ? 1 : 2;
        end
        m_pos++;
      end
      m_we = nxt_we;
    end
  end

  bit rand_restart = 1'b0;

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g;
    bit ok;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      byte_valid = 1'b0;
      byte_in = 8'($urandom);
      @(posedge clock); #1;
    end
    byte_valid = 1'b1;
    byte_in = b;
    if (rand_restart && $urandom_range(7, 0) == 0) restart = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock);
      ok = byte_ready;
      @(posedge clock); #1;
    end
    restart = 1'b0;
    byte_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int gap_max);
    foreach (q[i]) send_byte(q[i], gap_max);
  endtask

  task automatic make_frame(input int n, input bit bad,
                            output logic [7:0] q[$]);
    logic [7:0] x, b;
    q = {};
    x = '0;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      q.push_back(b);
    end
    q.push_back(bad ? ~x : x);
  endtask

  task automatic wait_end(input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      seen = done || error;
      if (!seen) begin @(posedge clock); #1; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL end_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
  endtask

  task automatic poke_ignored();
    repeat (3) begin
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
  endtask

  logic [7:0] frame_a[$];
  logic [7:0] q[$];
  int         wc0;

  initial begin
    frame_a = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    wr_count = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    chk("t1_ready", 32'(byte_ready), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd1);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_we", 32'(imem_we), 32'd0);
    chk("t1_addr", 32'(imem_addr), 32'd0);

    wc0 = wr_count;
    send_frame(frame_a, 0);
    wait_end(20);
    chk("t2_mem0", mem[0], 32'h20080005);
    chk("t2_mem1", mem[1], 32'h01095020);
    chk("t2_writes", 32'(wr_count - wc0), 32'd2);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd0);
    poke_ignored();

    pulse_restart();
    mem[0] = '0; mem[1] = '0;
    q = frame_a;
    q[10] = 8'h54;
    wc0 = wr_count;
    send_frame(q, 0);
    wait_end(20);
    chk("t3_mem1", mem[1], 32'h01095020);
    chk("t3_writes", 32'(wr_count - wc0), 32'd2);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_hold", 32'(cpu_hold), 32'd1);

    pulse_restart();
    wc0 = wr_count;
    q = '{8'h01, 8'h01};
    send_frame(q, 0);
    chk("t4_error", 32'(error), 32'd1);
    poke_ignored();
    chk("t4_writes", 32'(wr_count - wc0), 32'd0);

    pulse_restart();
    wc0 = wr_count;
    q = '{8'h00, 8'h00, 8'h00};
    send_frame(q, 0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_writes", 32'(wr_count - wc0), 32'd0);
    pulse_restart();
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    chk("t5_done_clr", 32'(done), 32'd0);
    chk("t5_ready", 32'(byte_ready), 32'd1);

    for (int i = 0; i < 5; i++) send_byte(frame_a[i], 3);
    reset_n = 1'b0;
    #1;
    chk("t6_ready", 32'(byte_ready), 32'd1);
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_wdata", imem_wdata, 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_flags", 32'({done, error}), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    mem[0] = '0; mem[1] = '0;
    wc0 = wr_count;
    send_frame(frame_a, 3);
    wait_end(20);
    chk("t6_mem0", mem[0], 32'h20080005);
    chk("t6_mem1", mem[1], 32'h01095020);
    chk("t6_writes", 32'(wr_count - wc0), 32'd2);
    chk("t6_done", 32'(done), 32'd1);

    rand_restart = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int n;
      n = (k == 5) ? DEPTH : int'($urandom_range(9, 0));
      if (k == 8) n = DEPTH + 1 + int'($urandom_range(300, 0));
      pulse_restart();
      make_frame(n, $urandom_range(3, 0) == 0, q);
      if (n > DEPTH) q = q[0:1];
      send_frame(q, (k == 5) ? 1 : 3);
      wait_end(20);
    end
    rand_restart = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
